// File: rtl/de_hazard_sequencer.sv
// Decode->execute hazard and CALL/RET sequencing controller for the D/E pipeline register.
// Optional build macro FORWARD_EN: E/M forwarding present, so only load-use hazards stall.
module de_hazard_sequencer #(
  parameter int unsigned RA_W    = 3,
  parameter int unsigned RET_TMO = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] dec_src1,
  input  logic [RA_W-1:0] dec_src2,
  input  logic            dec_use1,
  input  logic            dec_use2,
  input  logic            dec_call,
  input  logic            dec_ret,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_rw,
  input  logic            ex_mr,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_rw,
  input  logic            ex_br_taken,
  input  logic            ret_pc_load,
  output logic            pc_hold,
  output logic            fd_hold,
  output logic            fd_flush,
  output logic            de_bubble,
  output logic [1:0]      call_phase,
  output logic [1:0]      ret_phase,
  output logic            busy,
  output logic            ret_tmo_err
);

  localparam int unsigned CNT_W = (RET_TMO > 2) ? $clog2(RET_TMO) : 1;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_RUN, S_CALL1, S_CALL2, S_RET1, S_RET2, S_RET_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo_nxt;
  logic             match_ex, match_mem, hz;

  // With forwarding, only a load in E can still be a hazard and M never is.
  assign match_ex  = ex_rw & (ex_mr | !FWD) &
                     ((dec_use1 & (dec_src1 == ex_rd)) | (dec_use2 & (dec_src2 == ex_rd)));
  assign match_mem = mem_rw & !FWD &
                     ((dec_use1 & (dec_src1 == mem_rd)) | (dec_use2 & (dec_src2 == mem_rd)));
  assign hz        = match_ex | match_mem;

  assign busy = rst_n & (state != S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      cnt         <= '0;
      ret_tmo_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ret_tmo_err <= tmo_nxt;
    end
  end

  // Next state and combinational controls; everything forced low while reset is asserted.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    tmo_nxt    = ret_tmo_err;
    pc_hold    = 1'b0;
    fd_hold    = 1'b0;
    fd_flush   = 1'b0;
    de_bubble  = 1'b0;
    call_phase = 2'd0;
    ret_phase  = 2'd0;
    if (rst_n) begin
      case (state)
        S_CALL1:  call_phase = 2'd1;
        S_CALL2:  call_phase = 2'd2;
        S_RET1:   ret_phase  = 2'd1;
        S_RET2:   ret_phase  = 2'd2;
        default:  ;
      endcase
      if (ex_br_taken) begin
        fd_flush  = 1'b1;
        de_bubble = 1'b1;
        state_nxt = S_RUN;
      end else begin
        case (state)
          S_RUN: begin
            if (hz) begin
              pc_hold   = 1'b1;
              fd_hold   = 1'b1;
              de_bubble = 1'b1;
            end else if (dec_call) begin
              state_nxt = S_CALL1;
            end else if (dec_ret) begin
              state_nxt = S_RET1;
            end
          end
          S_CALL1: begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            state_nxt = S_CALL2;
          end
          S_CALL2: begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            state_nxt = S_RUN;
          end
          S_RET1: begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            state_nxt = S_RET2;
          end
          S_RET2: begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            state_nxt = S_RET_WAIT;
          end
          S_RET_WAIT: begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_bubble = 1'b1;
            if (ret_pc_load) begin
              fd_flush  = 1'b1;
              state_nxt = S_RUN;
            end else if (cnt == CNT_W'(RET_TMO - 1)) begin
              tmo_nxt   = 1'b1;
              state_nxt = S_RUN;
            end else begin
              cnt_nxt = CNT_W'(cnt + 1'b1);
            end
          end
          default: state_nxt = S_RUN;
        endcase
      end
    end
  end

endmodule
